// File: rtl/peak_detect_pkg.sv
// Shared types for the CP-correlation peak detector: sample widths,
// window geometry and the detector state encoding.
package peak_detect_pkg;

  localparam int MAG_W   = 16;
  localparam int GAMMA_W = 16;

  typedef logic        [MAG_W-1:0]   mag_t;
  typedef logic signed [GAMMA_W-1:0] gamma_t;

  localparam int PEAK_WIN_LEN = 80;
  localparam int PEAK_IDX_W   = $clog2(PEAK_WIN_LEN);

  typedef logic [PEAK_IDX_W-1:0] peak_idx_t;

  typedef enum logic [1:0] {
    PK_IDLE   = 2'd0,
    PK_SEARCH = 2'd1,
    PK_REPORT = 2'd2
  } pk_state_t;

endpackage

// File: rtl/peak_win_cnt.sv
// Window position counter: advances only on accepted samples, wraps
// from WIN_LEN-1 back to 0, and flags the final position of a window.
module peak_win_cnt #(
  parameter int WIN_LEN = 80,
  parameter int IDX_W   = $clog2(WIN_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  output logic [IDX_W-1:0] idx,
  output logic             last
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIN_LEN - 1);

  assign last = (idx == LAST_IDX);

  // Clear wins over counting so a restart always lands on index 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
    end else if (clear) begin
      idx <= '0;
    end else if (en) begin
      idx <= last ? '0 : idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/peak_detect.sv
// Per-window maximum search over the |gamma| stream. Reports index,
// magnitude and the complex gamma captured at the window peak.
module peak_detect
  import peak_detect_pkg::*;
#(
  parameter int WIN_LEN = PEAK_WIN_LEN,
  parameter int IDX_W   = $clog2(WIN_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             in_valid,
  input  mag_t             mag_in,
  input  gamma_t           gm_real,
  input  gamma_t           gm_imag,
  input  mag_t             thr_in,
  output logic             peak_valid,
  output logic             peak_found,
  output logic [IDX_W-1:0] peak_idx,
  output mag_t             peak_mag,
  output gamma_t           peak_gm_re,
  output gamma_t           peak_gm_im,
  output logic             busy
);

  pk_state_t        state;
  pk_state_t        state_next;
  logic [IDX_W-1:0] win_idx;
  logic             win_last;
  logic             accept;
  logic             report_edge;
  logic             take_sample;

  mag_t             best_mag;
  logic [IDX_W-1:0] best_idx;
  gamma_t           best_re;
  gamma_t           best_im;

  mag_t             fin_mag;
  logic [IDX_W-1:0] fin_idx;
  gamma_t           fin_re;
  gamma_t           fin_im;

  // A sample counts only while searching (REPORT included) and when no
  // stop/start is overriding the cycle.
  assign accept      = in_valid && (state != PK_IDLE) && !stop && !start;
  assign report_edge = accept && win_last;
  assign take_sample = (win_idx == '0) || (mag_in > best_mag);

  peak_win_cnt #(
    .WIN_LEN (WIN_LEN),
    .IDX_W   (IDX_W)
  ) u_win_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (start | stop),
    .en    (accept),
    .idx   (win_idx),
    .last  (win_last)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= PK_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: stop beats start, start beats normal window progress.
  always_comb begin
    state_next = state;
    if (stop) begin
      state_next = PK_IDLE;
    end else if (start) begin
      state_next = PK_SEARCH;
    end else if (state != PK_IDLE) begin
      state_next = report_edge ? PK_REPORT : PK_SEARCH;
    end
  end

  // Status outputs decoded from state.
  always_comb begin
    busy       = (state != PK_IDLE);
    peak_valid = (state == PK_REPORT);
  end

  // Window result including the sample on the current edge, so the last
  // sample of a window takes part in the final compare.
  always_comb begin
    fin_mag = best_mag;
    fin_idx = best_idx;
    fin_re  = best_re;
    fin_im  = best_im;
    if (take_sample) begin
      fin_mag = mag_in;
      fin_idx = win_idx;
      fin_re  = gm_real;
      fin_im  = gm_imag;
    end
  end

  // Running best: index 0 loads unconditionally, later samples only on a
  // strictly larger magnitude so ties keep the earliest index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_mag <= '0;
      best_idx <= '0;
      best_re  <= '0;
      best_im  <= '0;
    end else if (accept && take_sample) begin
      best_mag <= mag_in;
      best_idx <= win_idx;
      best_re  <= gm_real;
      best_im  <= gm_imag;
    end
  end

  // Reported result, updated only when a window completes and held otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_found <= 1'b0;
      peak_idx   <= '0;
      peak_mag   <= '0;
      peak_gm_re <= '0;
      peak_gm_im <= '0;
    end else if (report_edge) begin
      peak_found <= (fin_mag >= thr_in);
      peak_idx   <= fin_idx;
      peak_mag   <= fin_mag;
      peak_gm_re <= fin_re;
      peak_gm_im <= fin_im;
    end
  end

endmodule

// File: tb/tb_peak_detect.sv
// Testbench for peak_detect: directed scenarios plus a randomized run,
// all compared against a window-collecting reference model.
module tb_peak_detect;
  import peak_detect_pkg::*;

  localparam int WIN = PEAK_WIN_LEN;

  logic      clk = 1'b0;
  logic      rst;
  logic      start;
  logic      stop;
  logic      in_valid;
  mag_t      mag_in;
  gamma_t    gm_real;
  gamma_t    gm_imag;
  mag_t      thr_in;
  logic      peak_valid;
  logic      peak_found;
  peak_idx_t peak_idx;
  mag_t      peak_mag;
  gamma_t    peak_gm_re;
  gamma_t    peak_gm_im;
  logic      busy;

  int total = 0;
  int bad   = 0;

  // Reference model state: whether a search is running, the samples of
  // the current window, and the most recently reported result.
  bit        m_active;
  mag_t      win_mag[$];
  gamma_t    win_re[$];
  gamma_t    win_im[$];
  bit        e_valid;
  bit        e_found;
  peak_idx_t e_idx;
  mag_t      e_mag;
  gamma_t    e_re;
  gamma_t    e_im;

  peak_detect dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .in_valid   (in_valid),
    .mag_in     (mag_in),
    .gm_real    (gm_real),
    .gm_imag    (gm_imag),
    .thr_in     (thr_in),
    .peak_valid (peak_valid),
    .peak_found (peak_found),
    .peak_idx   (peak_idx),
    .peak_mag   (peak_mag),
    .peak_gm_re (peak_gm_re),
    .peak_gm_im (peak_gm_im),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    win_mag.delete();
    win_re.delete();
    win_im.delete();
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    model_clear();
    e_valid = 1'b0;
    e_found = 1'b0;
    e_idx   = '0;
    e_mag   = '0;
    e_re    = '0;
    e_im    = '0;
  endtask

  // Applies one clock edge to the model using the inputs the DUT sampled.
  task automatic model_edge();
    int bi;
    e_valid = 1'b0;
    if (stop) begin
      m_active = 1'b0;
      model_clear();
    end else if (start) begin
      m_active = 1'b1;
      model_clear();
    end else if (m_active && in_valid) begin
      win_mag.push_back(mag_in);
      win_re.push_back(gm_real);
      win_im.push_back(gm_imag);
      if (win_mag.size() == WIN) begin
        bi = 0;
        for (int k = 1; k < WIN; k++) begin
          if (win_mag[k] > win_mag[bi]) bi = k;
        end
        e_valid = 1'b1;
        e_idx   = peak_idx_t'(bi);
        e_mag   = win_mag[bi];
        e_re    = win_re[bi];
        e_im    = win_im[bi];
        e_found = (win_mag[bi] >= thr_in);
        model_clear();
      end
    end
  endtask

  task automatic check_all(input string tag);
    check_output({tag, "_valid"}, 32'(peak_valid), 32'(e_valid));
    check_output({tag, "_busy"},  32'(busy),       32'(m_active));
    check_output({tag, "_found"}, 32'(peak_found), 32'(e_found));
    check_output({tag, "_idx"},   32'(peak_idx),   32'(e_idx));
    check_output({tag, "_mag"},   32'(peak_mag),   32'(e_mag));
    check_output({tag, "_re"},    32'(peak_gm_re), 32'(e_re));
    check_output({tag, "_im"},    32'(peak_gm_im), 32'(e_im));
  endtask

  // Drives one cycle of inputs from the falling edge, then checks outputs
  // on the next falling edge, clear of the active edge.
  task automatic apply_stimulus(input string tag, input bit s, input bit p, input bit v,
                                input mag_t m, input gamma_t r, input gamma_t i);
    start    = s;
    stop     = p;
    in_valid = v;
    mag_in   = m;
    gm_real  = r;
    gm_imag  = i;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    int rnd_bad;
    rst = 1'b1; start = 1'b0; stop = 1'b0; in_valid = 1'b0;
    mag_in = '0; gm_real = '0; gm_imag = '0; thr_in = 16'd40;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    rst = 1'b0;
    @(negedge clk);

    // Contiguous ramp 0..79: maximum is the final sample.
    apply_stimulus("t2_start", 1, 0, 0, '0, '0, '0);
    for (int k = 0; k < WIN; k++)
      apply_stimulus("t2", 0, 0, 1, mag_t'(k), gamma_t'(k), gamma_t'(-k));
    check_output("t2_pv",  32'(peak_valid), 32'd1);
    check_output("t2_idx", 32'(peak_idx),   32'd79);
    check_output("t2_mag", 32'(peak_mag),   32'd79);

    // Tied peaks at 10 and 50: the earlier index must win.
    apply_stimulus("t3_start", 1, 0, 0, '0, '0, '0);
    for (int k = 0; k < WIN; k++)
      apply_stimulus("t3", 0, 0, 1, (k == 10 || k == 50) ? mag_t'(100) : mag_t'(5),
                     gamma_t'(1000 + k), gamma_t'(-2000 - k));
    check_output("t3_idx", 32'(peak_idx),   32'd10);
    check_output("t3_re",  32'(peak_gm_re), 32'(gamma_t'(1010)));
    check_output("t3_im",  32'(peak_gm_im), 32'(gamma_t'(-2010)));

    // Ramp with an idle gap after every sample: same result.
    apply_stimulus("t4_start", 1, 0, 0, '0, '0, '0);
    for (int k = 0; k < WIN; k++) begin
      apply_stimulus("t4", 0, 0, 1, mag_t'(k), gamma_t'(k), gamma_t'(-k));
      if (k < WIN - 1) apply_stimulus("t4_gap", 0, 0, 0, 16'hFFFF, '0, '0);
    end
    check_output("t4_pv",  32'(peak_valid), 32'd1);
    check_output("t4_idx", 32'(peak_idx),   32'd79);

    // Threshold above, then equal to, the window maximum.
    for (int pass = 0; pass < 2; pass++) begin
      thr_in = (pass == 0) ? mag_t'(200) : mag_t'(150);
      apply_stimulus("t5_start", 1, 0, 0, '0, '0, '0);
      for (int k = 0; k < WIN; k++)
        apply_stimulus("t5", 0, 0, 1, (k == 33) ? mag_t'(150) : mag_t'(k % 20), '0, '0);
      check_output("t5_pv",    32'(peak_valid), 32'd1);
      check_output("t5_found", 32'(peak_found), (pass == 0) ? 32'd0 : 32'd1);
    end

    // Restart mid-window, then three back-to-back windows.
    apply_stimulus("t6_start", 1, 0, 0, '0, '0, '0);
    for (int k = 0; k < 40; k++)
      apply_stimulus("t6_part", 0, 0, 1, mag_t'(500 + k), '0, '0);
    apply_stimulus("t6_restart", 1, 0, 1, mag_t'(900), '0, '0);
    for (int k = 0; k < 3 * WIN; k++)
      apply_stimulus("t6_b2b", 0, 0, 1, mag_t'($urandom_range(0, 300)),
                     gamma_t'($urandom), gamma_t'($urandom));

    // Stop mid-window: inputs ignored, last report held.
    for (int k = 0; k < 30; k++)
      apply_stimulus("stop_pre", 0, 0, 1, mag_t'($urandom_range(0, 50)), '0, '0);
    apply_stimulus("stop", 0, 1, 1, mag_t'(999), '0, '0);
    for (int k = 0; k < 100; k++)
      apply_stimulus("stop_idle", 0, 0, 1, mag_t'(2000), gamma_t'(7), gamma_t'(7));

    // Randomized traffic with occasional restarts, stops and threshold changes.
    for (int k = 0; k < 4000; k++) begin
      bit s, p;
      s = m_active ? ($urandom_range(0, 399) == 0) : ($urandom_range(0, 4) == 0);
      p = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 199) == 0) thr_in = mag_t'($urandom_range(0, 20));
      apply_stimulus("rand", s, p, ($urandom_range(0, 9) < 7),
                     mag_t'($urandom_range(0, 20)), gamma_t'($urandom), gamma_t'($urandom));
    end

    // Asynchronous reset mid-search, between clock edges.
    apply_stimulus("t1_start", 1, 0, 0, '0, '0, '0);
    for (int k = 0; k < WIN + 20; k++)
      apply_stimulus("t1_pre", 0, 0, 1, mag_t'(k + 1), gamma_t'(k + 3), gamma_t'(k + 5));
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("t1_async");
    rnd_bad = 0;
    @(negedge clk);
    rst = 1'b0;
    apply_stimulus("t1_idle", 0, 0, 1, mag_t'(77), '0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
